frame_buf_sched: RTL and testbench
==================================

# frame_buf_sched

Frame-buffer ownership scheduler between one sensor-side frame writer and one readout-side frame reader sharing a pool of NUM_BUFS DRAM frame buffers. Each buffer is tracked as FREE, WRITING, READY, READING or SHOWN. The block grants the writer a buffer base address per frame and hands the reader the newest completed frame. It drops stale frames when the writer laps the reader and repeats the last shown frame when the reader outruns the writer. It supplies the base address consumed by the writer-side address generator and the readout DMA.

## Interface
- NUM_BUFS, 4, number of buffers; legal 3 or 4
- BASE_ADDR, 32'h0F800000, base of buffer 0
- BUF_STRIDE, 32'h00400000, byte distance between consecutive buffers
- sys_clk  in  1  system clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- wr_frame_start  in  1  1-cycle pulse, writer begins a frame
- wr_frame_done  in  1  1-cycle pulse, writer completed its frame
- wr_grant  out  1  writer owns a buffer
- wr_idx  out  2  buffer index granted to writer
- wr_base  out  32  BASE_ADDR + wr_idx*BUF_STRIDE
- rd_frame_start  in  1  1-cycle pulse, reader begins a frame
- rd_frame_done  in  1  1-cycle pulse, reader finished its frame
- rd_valid  out  1  reader owns a buffer
- rd_idx  out  2  buffer index granted to reader
- rd_base  out  32  BASE_ADDR + rd_idx*BUF_STRIDE
- drop_cnt  out  16  completed frames discarded unread, saturating
- repeat_cnt  out  16  frames re-issued to reader, saturating

## Operation
- Per-buffer state (3 bits) plus 8-bit stamp; frame_seq (8 bit) increments on each accepted wr_frame_done; stamp = frame_seq value before increment; age = frame_seq - stamp mod 256. Newest READY = minimum age, oldest = maximum age.
- Invariants: at most one WRITING, one READING and one SHOWN buffer.
- Events in a cycle are applied in this fixed order, each seeing the state left by the previous one: wr_frame_done, rd_frame_done, rd_frame_start, wr_frame_start.
- wr_frame_done: WRITING -> READY, stamp and increment frame_seq, wr_grant cleared. Ignored if no WRITING buffer.
- rd_frame_done: READING -> SHOWN, and any old SHOWN -> FREE. Ignored if no READING buffer.
- rd_frame_start:
  - An existing READING buffer is first treated as rd_frame_done.
  - If any READY buffer exists: newest READY -> READING. Old SHOWN -> FREE. Every other READY -> FREE, with drop_cnt += 1 per buffer.
  - Else if a SHOWN buffer exists: SHOWN -> READING, repeat_cnt += 1.
  - Else: rd_valid = 0 and no state change.
- wr_frame_start:
  - An existing WRITING buffer is first aborted to FREE; an abort does not count as a drop.
  - Allocation order: first FREE found by round-robin search starting at wr_ptr+1 mod NUM_BUFS; else oldest READY (drop_cnt += 1); else SHOWN.
  - The chosen buffer -> WRITING, and wr_ptr = chosen index.
  - With NUM_BUFS >= 3, allocation always succeeds.
- Both counters saturate at 16'hFFFF and never wrap.

## Timing
- All outputs are registered and reflect events one cycle after the input pulse (latency 1). No combinational input-to-output path.
- wr_grant rises the cycle after an accepted wr_frame_start and falls the cycle after wr_frame_done. On abort-restart it stays high and wr_idx/wr_base switch the next cycle.
- rd_valid/rd_idx behave identically for the reader.
- While wr_grant = 0, wr_idx/wr_base hold their last value; the same holds for rd_idx/rd_base while rd_valid = 0.
- Reset (asynchronous assert, synchronous deassert from the system):
  - all buffers FREE, stamps 0, frame_seq 0, wr_ptr = NUM_BUFS-1
  - wr_grant = 0, rd_valid = 0, wr_idx = rd_idx = 0, wr_base = rd_base = BASE_ADDR
  - drop_cnt = repeat_cnt = 0
- Reset asserted mid-frame discards all ownership at once. The first wr_frame_start after reset grants buffer 0.
- Indices >= NUM_BUFS are never produced.

## Test plan
- Reset, then wr_frame_start -> next cycle wr_grant=1, wr_idx=0, wr_base=0x0F800000. Second frame after done -> wr_idx=1, wr_base=0x0FC00000.
- Write frames into buf0 and buf1 (both done), then rd_frame_start -> rd_valid=1, rd_idx=1, drop_cnt=1, buf0 FREE. Next wr_frame_start -> wr_idx=2.
- Reader done on buf1, no new frame, rd_frame_start -> rd_idx=1 again, repeat_cnt=1. Reader before any write -> rd_valid stays 0, counters 0.
- NUM_BUFS=4, reader holds buf0; writer completes frames into buf1, buf2 and buf3, then starts again -> wr_idx=1 (oldest READY stolen), drop_cnt=1.
- wr_frame_done and rd_frame_start in the same cycle -> reader receives the just-completed buffer. wr_frame_start in the same cycle as rd_frame_start -> writer gets the SHOWN buffer freed by the reader when no FREE buffer is left.
- Assert sys_rst_n low between clock edges with wr_grant=1 and rd_valid=1 -> both outputs drop immediately with no clock edge. After release, wr_frame_start grants idx 0 and drop_cnt=0.

Source files
------------

// File: rtl/frame_buf_sched_if.sv
// Frame-buffer handshake bundle between the writer/reader clients and the
// buffer ownership scheduler.
interface frame_buf_sched_if;
  logic        wr_frame_start;
  logic        wr_frame_done;
  logic        wr_grant;
  logic [1:0]  wr_idx;
  logic [31:0] wr_base;
  logic        rd_frame_start;
  logic        rd_frame_done;
  logic        rd_valid;
  logic [1:0]  rd_idx;
  logic [31:0] rd_base;

  // Client side: issues frame pulses, receives buffer grants.
  modport master (
    output wr_frame_start, wr_frame_done, rd_frame_start, rd_frame_done,
    input  wr_grant, wr_idx, wr_base, rd_valid, rd_idx, rd_base
  );

  // Scheduler side: consumes frame pulses, drives buffer grants.
  modport slave (
    input  wr_frame_start, wr_frame_done, rd_frame_start, rd_frame_done,
    output wr_grant, wr_idx, wr_base, rd_valid, rd_idx, rd_base
  );
endinterface

// File: rtl/frame_buf_sched.sv
// Frame-buffer ownership scheduler: hands the sensor writer a free buffer per
// frame and the readout reader the newest completed frame. Stale frames are
// dropped when the writer laps the reader; the last shown frame is repeated
// when the reader outruns the writer. NUM_BUFS must be 3 or 4.
module frame_buf_sched #(
  parameter int          NUM_BUFS   = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0F800000,
  parameter logic [31:0] BUF_STRIDE = 32'h00400000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  frame_buf_sched_if.slave bus,
  output logic [15:0]      drop_cnt,
  output logic [15:0]      repeat_cnt
);

  typedef enum logic [2:0] {
    ST_FREE,
    ST_WRITING,
    ST_READY,
    ST_READING,
    ST_SHOWN
  } bufState_t;

  bufState_t   r_bufState [NUM_BUFS];
  logic [7:0]  r_stamp    [NUM_BUFS];
  logic [7:0]  r_frameSeq;
  logic [1:0]  r_wrPtr;
  logic        r_wrGrant;
  logic [1:0]  r_wrIdx;
  logic [31:0] r_wrBase;
  logic        r_rdValid;
  logic [1:0]  r_rdIdx;
  logic [31:0] r_rdBase;
  logic [15:0] r_dropCnt;
  logic [15:0] r_repeatCnt;

  bufState_t   w_bufState [NUM_BUFS];
  logic [7:0]  w_stamp    [NUM_BUFS];
  logic [7:0]  w_frameSeq;
  logic [1:0]  w_wrPtr;
  logic        w_wrGrant;
  logic [1:0]  w_wrIdx;
  logic [31:0] w_wrBase;
  logic        w_rdValid;
  logic [1:0]  w_rdIdx;
  logic [31:0] w_rdBase;
  logic [2:0]  w_dropInc;
  logic        w_repeatInc;
  logic [16:0] w_dropSum;
  logic [16:0] w_repeatSum;
  logic        w_hit;
  logic [1:0]  w_pick;
  logic [1:0]  w_slot;
  logic [7:0]  w_age;
  logic [7:0]  w_bestAge;

  // Next-state: apply writer-done, reader-done, reader-start, writer-start in
  // that order, each step operating on the buffer table left by the previous.
  always_comb begin
    for (int i = 0; i < NUM_BUFS; i++) begin
      w_bufState[i] = r_bufState[i];
      w_stamp[i]    = r_stamp[i];
    end
    w_frameSeq  = r_frameSeq;
    w_wrPtr     = r_wrPtr;
    w_wrIdx     = r_wrIdx;
    w_rdIdx     = r_rdIdx;
    w_dropInc   = 3'd0;
    w_repeatInc = 1'b0;
    w_hit       = 1'b0;
    w_pick      = 2'd0;
    w_slot      = 2'd0;
    w_age       = 8'd0;
    w_bestAge   = 8'd0;

    // Writer finished: publish the frame stamped with the current sequence.
    if (bus.wr_frame_done) begin
      for (int i = 0; i < NUM_BUFS; i++) begin
        if (w_bufState[i] == ST_WRITING) begin
          w_bufState[i] = ST_READY;
          w_stamp[i]    = r_frameSeq;
          w_frameSeq    = r_frameSeq + 8'd1;
        end
      end
    end

    // Reader finished (explicitly, or implicitly by starting a new frame):
    // the read buffer becomes the shown one and the previous shown is freed.
    if (bus.rd_frame_done || bus.rd_frame_start) begin
      w_hit = 1'b0;
      for (int i = 0; i < NUM_BUFS; i++) begin
        if (w_bufState[i] == ST_READING) w_hit = 1'b1;
      end
      if (w_hit) begin
        for (int i = 0; i < NUM_BUFS; i++) begin
          if (w_bufState[i] == ST_SHOWN) w_bufState[i] = ST_FREE;
          else if (w_bufState[i] == ST_READING) w_bufState[i] = ST_SHOWN;
        end
      end
    end

    // Reader start: take the newest ready frame and discard the older ones,
    // otherwise fall back to repeating the shown frame.
    if (bus.rd_frame_start) begin
      w_hit     = 1'b0;
      w_pick    = 2'd0;
      w_bestAge = 8'hFF;
      for (int i = 0; i < NUM_BUFS; i++) begin
        w_age = w_frameSeq - w_stamp[i];
        if (w_bufState[i] == ST_READY && (!w_hit || w_age < w_bestAge)) begin
          w_hit     = 1'b1;
          w_bestAge = w_age;
          w_pick    = 2'(i);
        end
      end
      if (w_hit) begin
        for (int i = 0; i < NUM_BUFS; i++) begin
          if (2'(i) == w_pick) begin
            w_bufState[i] = ST_READING;
          end else if (w_bufState[i] == ST_READY) begin
            w_bufState[i] = ST_FREE;
            w_dropInc     = w_dropInc + 3'd1;
          end else if (w_bufState[i] == ST_SHOWN) begin
            w_bufState[i] = ST_FREE;
          end
        end
        w_rdIdx = w_pick;
      end else begin
        for (int i = 0; i < NUM_BUFS; i++) begin
          if (w_bufState[i] == ST_SHOWN) begin
            w_bufState[i] = ST_READING;
            w_repeatInc   = 1'b1;
            w_rdIdx       = 2'(i);
          end
        end
      end
    end

    // Writer start: abort any frame in progress, then allocate round-robin
    // from the free pool, stealing the oldest ready frame or the shown frame
    // when nothing is free.
    if (bus.wr_frame_start) begin
      for (int i = 0; i < NUM_BUFS; i++) begin
        if (w_bufState[i] == ST_WRITING) w_bufState[i] = ST_FREE;
      end
      w_hit  = 1'b0;
      w_pick = 2'd0;
      for (int k = 1; k <= NUM_BUFS; k++) begin
        w_slot = 2'((int'(r_wrPtr) + k) % NUM_BUFS);
        if (!w_hit && w_bufState[w_slot] == ST_FREE) begin
          w_hit  = 1'b1;
          w_pick = w_slot;
        end
      end
      if (!w_hit) begin
        w_bestAge = 8'd0;
        for (int i = 0; i < NUM_BUFS; i++) begin
          w_age = w_frameSeq - w_stamp[i];
          if (w_bufState[i] == ST_READY && (!w_hit || w_age > w_bestAge)) begin
            w_hit     = 1'b1;
            w_bestAge = w_age;
            w_pick    = 2'(i);
          end
        end
        if (w_hit) w_dropInc = w_dropInc + 3'd1;
      end
      if (!w_hit) begin
        for (int i = 0; i < NUM_BUFS; i++) begin
          if (!w_hit && w_bufState[i] == ST_SHOWN) begin
            w_hit  = 1'b1;
            w_pick = 2'(i);
          end
        end
      end
      if (w_hit) begin
        w_bufState[w_pick] = ST_WRITING;
        w_wrPtr            = w_pick;
        w_wrIdx            = w_pick;
      end
    end

    w_wrGrant = 1'b0;
    w_rdValid = 1'b0;
    for (int i = 0; i < NUM_BUFS; i++) begin
      if (w_bufState[i] == ST_WRITING) w_wrGrant = 1'b1;
      if (w_bufState[i] == ST_READING) w_rdValid = 1'b1;
    end
    w_wrBase    = BASE_ADDR + 32'(w_wrIdx) * BUF_STRIDE;
    w_rdBase    = BASE_ADDR + 32'(w_rdIdx) * BUF_STRIDE;
    w_dropSum   = {1'b0, r_dropCnt} + {14'd0, w_dropInc};
    w_repeatSum = {1'b0, r_repeatCnt} + {16'd0, w_repeatInc};
  end

  // State and output registers; reset discards all buffer ownership at once.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NUM_BUFS; i++) begin
        r_bufState[i] <= ST_FREE;
        r_stamp[i]    <= 8'd0;
      end
      r_frameSeq  <= 8'd0;
      r_wrPtr     <= 2'(NUM_BUFS - 1);
      r_wrGrant   <= 1'b0;
      r_wrIdx     <= 2'd0;
      r_wrBase    <= BASE_ADDR;
      r_rdValid   <= 1'b0;
      r_rdIdx     <= 2'd0;
      r_rdBase    <= BASE_ADDR;
      r_dropCnt   <= 16'd0;
      r_repeatCnt <= 16'd0;
    end else begin
      for (int i = 0; i < NUM_BUFS; i++) begin
        r_bufState[i] <= w_bufState[i];
        r_stamp[i]    <= w_stamp[i];
      end
      r_frameSeq  <= w_frameSeq;
      r_wrPtr     <= w_wrPtr;
      r_wrGrant   <= w_wrGrant;
      r_wrIdx     <= w_wrIdx;
      r_wrBase    <= w_wrBase;
      r_rdValid   <= w_rdValid;
      r_rdIdx     <= w_rdIdx;
      r_rdBase    <= w_rdBase;
      r_dropCnt   <= w_dropSum[16] ? 16'hFFFF : w_dropSum[15:0];
      r_repeatCnt <= w_repeatSum[16] ? 16'hFFFF : w_repeatSum[15:0];
    end
  end

  assign bus.wr_grant = r_wrGrant;
  assign bus.wr_idx   = r_wrIdx;
  assign bus.wr_base  = r_wrBase;
  assign bus.rd_valid = r_rdValid;
  assign bus.rd_idx   = r_rdIdx;
  assign bus.rd_base  = r_rdBase;
  assign drop_cnt     = r_dropCnt;
  assign repeat_cnt   = r_repeatCnt;

endmodule

// File: tb/tb_frame_buf_sched.sv
// Testbench for frame_buf_sched: directed frame-pulse sequences checked every
// cycle against a queue-based ownership model, plus hand-computed pins.
module tb_frame_buf_sched;
  localparam int          NB     = 4;
  localparam logic [31:0] BASE   = 32'h0F800000;
  localparam logic [31:0] STRIDE = 32'h00400000;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [15:0] drop_cnt;
  logic [15:0] repeat_cnt;
  int          vectors;
  int          miscompares;
  logic        cmpEn;

  frame_buf_sched_if busIf ();

  frame_buf_sched #(
    .NUM_BUFS  (NB),
    .BASE_ADDR (BASE),
    .BUF_STRIDE(STRIDE)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (busIf),
    .drop_cnt  (drop_cnt),
    .repeat_cnt(repeat_cnt)
  );

  // Free-running system clock.
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Ownership model: who writes, who reads, what is shown, and the list of
  // completed frames from oldest to newest; anything else is free.
  int mWriting;
  int mReading;
  int mShown;
  int mReadyQ[$];
  int mWrPtr;
  int mDrops;
  int mRepeats;
  int mWrIdx;
  int mRdIdx;

  function automatic void modelReset();
    mWriting = -1;
    mReading = -1;
    mShown   = -1;
    mReadyQ.delete();
    mWrPtr   = NB - 1;
    mDrops   = 0;
    mRepeats = 0;
    mWrIdx   = 0;
    mRdIdx   = 0;
  endfunction

  function automatic bit modelIsFree(int c);
    if (c == mWriting || c == mReading || c == mShown) return 0;
    foreach (mReadyQ[j]) if (mReadyQ[j] == c) return 0;
    return 1;
  endfunction

  function automatic void modelStep(bit wS, bit wD, bit rS, bit rD);
    int pick;
    if (wD && mWriting >= 0) begin
      mReadyQ.push_back(mWriting);
      mWriting = -1;
    end
    if ((rD || rS) && mReading >= 0) begin
      mShown   = mReading;
      mReading = -1;
    end
    if (rS) begin
      if (mReadyQ.size() > 0) begin
        mReading = mReadyQ.pop_back();
        mDrops  += mReadyQ.size();
        mReadyQ.delete();
        mShown   = -1;
        mRdIdx   = mReading;
      end else if (mShown >= 0) begin
        mReading = mShown;
        mShown   = -1;
        mRepeats++;
        mRdIdx   = mReading;
      end
    end
    if (wS) begin
      mWriting = -1;
      pick = -1;
      for (int k = 1; k <= NB; k++) begin
        if (pick < 0 && modelIsFree((mWrPtr + k) % NB)) pick = (mWrPtr + k) % NB;
      end
      if (pick < 0 && mReadyQ.size() > 0) begin
        pick = mReadyQ.pop_front();
        mDrops++;
      end
      if (pick < 0 && mShown >= 0) begin
        pick  = mShown;
        mShown = -1;
      end
      mWriting = pick;
      mWrPtr   = pick;
      mWrIdx   = pick;
    end
    if (mDrops > 65535) mDrops = 65535;
    if (mRepeats > 65535) mRepeats = 65535;
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of frame pulses at the falling edge, advance the model,
  // and clear the pulses just after the DUT has sampled them.
  task automatic applyStimulus(bit wS, bit wD, bit rS, bit rD);
    @(negedge sys_clk);
    busIf.wr_frame_start = wS;
    busIf.wr_frame_done  = wD;
    busIf.rd_frame_start = rS;
    busIf.rd_frame_done  = rD;
    modelStep(wS, wD, rS, rD);
    @(posedge sys_clk);
    #2;
    busIf.wr_frame_start = 1'b0;
    busIf.wr_frame_done  = 1'b0;
    busIf.rd_frame_start = 1'b0;
    busIf.rd_frame_done  = 1'b0;
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(posedge sys_clk) begin
    #1;
    if (cmpEn) begin
      checkOutput("wr_grant", 32'(busIf.wr_grant), 32'(mWriting >= 0));
      checkOutput("wr_idx", 32'(busIf.wr_idx), 32'(mWrIdx));
      checkOutput("wr_base", busIf.wr_base, BASE + 32'(mWrIdx) * STRIDE);
      checkOutput("rd_valid", 32'(busIf.rd_valid), 32'(mReading >= 0));
      checkOutput("rd_idx", 32'(busIf.rd_idx), 32'(mRdIdx));
      checkOutput("rd_base", busIf.rd_base, BASE + 32'(mRdIdx) * STRIDE);
      checkOutput("drop_cnt", 32'(drop_cnt), 32'(mDrops));
      checkOutput("repeat_cnt", 32'(repeat_cnt), 32'(mRepeats));
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    cmpEn       = 1'b0;
    busIf.wr_frame_start = 1'b0;
    busIf.wr_frame_done  = 1'b0;
    busIf.rd_frame_start = 1'b0;
    busIf.rd_frame_done  = 1'b0;
    sys_rst_n = 1'b0;
    modelReset();
    cmpEn = 1'b1;
    repeat (3) @(negedge sys_clk);
    checkOutput("pin_rst_wr_grant", 32'(busIf.wr_grant), 32'd0);
    checkOutput("pin_rst_wr_base", busIf.wr_base, 32'h0F800000);
    checkOutput("pin_rst_rd_base", busIf.rd_base, 32'h0F800000);
    checkOutput("pin_rst_drop", 32'(drop_cnt), 32'd0);
    sys_rst_n = 1'b1;

    // Reader before any frame exists.
    applyStimulus(0, 0, 1, 0);
    checkOutput("pin_early_rd_valid", 32'(busIf.rd_valid), 32'd0);
    checkOutput("pin_early_repeat", 32'(repeat_cnt), 32'd0);

    // First two frames land in buffers 0 and 1.
    applyStimulus(1, 0, 0, 0);
    checkOutput("pin_w0_grant", 32'(busIf.wr_grant), 32'd1);
    checkOutput("pin_w0_idx", 32'(busIf.wr_idx), 32'd0);
    checkOutput("pin_w0_base", busIf.wr_base, 32'h0F800000);
    applyStimulus(0, 1, 0, 0);
    checkOutput("pin_w0_done_grant", 32'(busIf.wr_grant), 32'd0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("pin_w1_idx", 32'(busIf.wr_idx), 32'd1);
    checkOutput("pin_w1_base", busIf.wr_base, 32'h0FC00000);
    applyStimulus(0, 1, 0, 0);

    // Reader takes newest (buf1) and drops buf0.
    applyStimulus(0, 0, 1, 0);
    checkOutput("pin_rd_newest_idx", 32'(busIf.rd_idx), 32'd1);
    checkOutput("pin_rd_newest_valid", 32'(busIf.rd_valid), 32'd1);
    checkOutput("pin_rd_newest_drop", 32'(drop_cnt), 32'd1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("pin_w2_idx", 32'(busIf.wr_idx), 32'd2);

    // Reader outruns writer: shown frame repeated.
    applyStimulus(0, 0, 0, 1);
    checkOutput("pin_rd_done_valid", 32'(busIf.rd_valid), 32'd0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("pin_repeat_idx", 32'(busIf.rd_idx), 32'd1);
    checkOutput("pin_repeat_cnt", 32'(repeat_cnt), 32'd1);

    // Writer done and reader start in the same cycle.
    applyStimulus(0, 1, 1, 0);
    checkOutput("pin_same_cycle_rd_idx", 32'(busIf.rd_idx), 32'd2);
    checkOutput("pin_same_cycle_grant", 32'(busIf.wr_grant), 32'd0);

    // Writer laps the reader holding buf2: oldest ready (buf3) stolen.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("pin_steal_idx", 32'(busIf.wr_idx), 32'd3);
    checkOutput("pin_steal_drop", 32'(drop_cnt), 32'd2);

    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 0, 1, 0);
    checkOutput("pin_mix1_rd_idx", 32'(busIf.rd_idx), 32'd3);
    checkOutput("pin_mix1_wr_idx", 32'(busIf.wr_idx), 32'd0);
    checkOutput("pin_mix1_drop", 32'(drop_cnt), 32'd4);

    // Writer receives the shown buffer the reader frees in the same cycle.
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 0, 1, 0);
    checkOutput("pin_shown_reuse_wr_idx", 32'(busIf.wr_idx), 32'd3);
    checkOutput("pin_shown_reuse_wr_base", busIf.wr_base, 32'h10400000);
    checkOutput("pin_shown_reuse_rd_idx", 32'(busIf.rd_idx), 32'd2);
    checkOutput("pin_shown_reuse_rd_base", busIf.rd_base, 32'h10000000);
    checkOutput("pin_shown_reuse_drop", 32'(drop_cnt), 32'd6);
    applyStimulus(0, 0, 0, 0);

    // Reset mid-frame between edges: ownership vanishes without a clock.
    @(negedge sys_clk);
    #3;
    sys_rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("pin_async_rst_grant", 32'(busIf.wr_grant), 32'd0);
    checkOutput("pin_async_rst_valid", 32'(busIf.rd_valid), 32'd0);
    checkOutput("pin_async_rst_drop", 32'(drop_cnt), 32'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;

    applyStimulus(1, 0, 0, 0);
    checkOutput("pin_post_rst_idx", 32'(busIf.wr_idx), 32'd0);
    checkOutput("pin_post_rst_drop", 32'(drop_cnt), 32'd0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("pin_hold0_rd_idx", 32'(busIf.rd_idx), 32'd0);
    for (int n = 0; n < 3; n++) begin
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 1, 0, 0);
    end
    applyStimulus(1, 0, 0, 0);
    checkOutput("pin_lap_idx", 32'(busIf.wr_idx), 32'd1);
    checkOutput("pin_lap_drop", 32'(drop_cnt), 32'd1);

    // Abort-restart keeps the grant and is not counted as a drop.
    applyStimulus(1, 0, 0, 0);
    checkOutput("pin_abort_grant", 32'(busIf.wr_grant), 32'd1);
    checkOutput("pin_abort_idx", 32'(busIf.wr_idx), 32'd1);
    checkOutput("pin_abort_drop", 32'(drop_cnt), 32'd1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    cmpEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
